// File: rtl/ydot_engine.sv
// Complex dot-product engine: streams <row, column c> for c = 0..NCOL-1 through a
// two-stage pipeline (lane products, then lane sum + shift + saturate) with valid/ready output.
module ydot_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int LANES = 4,
    parameter int NCOL  = 2,
    localparam int IW   = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_conj,
    input  logic [LANES*WIDTH-1:0]       i_row_r,
    input  logic [LANES*WIDTH-1:0]       i_row_i,
    input  logic [NCOL*LANES*WIDTH-1:0]  i_col_r,
    input  logic [NCOL*LANES*WIDTH-1:0]  i_col_i,
    output logic                         o_out_valid,
    input  logic                         i_out_ready,
    output logic [WIDTH-1:0]             o_out_r,
    output logic [WIDTH-1:0]             o_out_i,
    output logic [IW-1:0]                o_out_idx,
    output logic                         o_busy,
    output logic                         o_done
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_RUN   | issuing columns into stage 1
    // S_DRAIN | all columns issued, results still in the pipe

    localparam int PW = 2*WIDTH + 1;
    localparam int SW = PW + $clog2(LANES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCOL - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'({1'b0, {(WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IW-1:0]         r_cnt;
    logic                  r_conj;
    logic                  r_s1_valid;
    logic [IW-1:0]         r_s1_idx;
    logic signed [PW-1:0]  r_pr [LANES];
    logic signed [PW-1:0]  r_pi [LANES];
    logic signed [PW-1:0]  w_pr [LANES];
    logic signed [PW-1:0]  w_pi [LANES];
    logic signed [SW-1:0]  w_sum_r;
    logic signed [SW-1:0]  w_sum_i;
    logic signed [SW-1:0]  w_sh_r;
    logic signed [SW-1:0]  w_sh_i;
    logic                  w_advance;
    logic                  w_issue;
    logic                  w_last_hs;
    logic                  r_done;

    assign w_advance = !o_out_valid || i_out_ready;
    assign w_issue   = (r_state == S_RUN) && w_advance;
    assign w_last_hs = (r_state == S_DRAIN) && o_out_valid && i_out_ready
                       && (o_out_idx == LAST_IDX);
    assign o_done    = r_done;

    // Column r_cnt is selected directly from the (held-stable) column bus.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic signed [WIDTH-1:0] w_ar, w_ai, w_br, w_bi;
        logic signed [PW-1:0]    w_rr, w_ii, w_ri, w_ir;
        assign w_ar = i_row_r[k*WIDTH +: WIDTH];
        assign w_ai = i_row_i[k*WIDTH +: WIDTH];
        assign w_br = i_col_r[(int'(r_cnt)*LANES + k)*WIDTH +: WIDTH];
        assign w_bi = i_col_i[(int'(r_cnt)*LANES + k)*WIDTH +: WIDTH];
        assign w_rr = PW'(w_ar) * PW'(w_br);
        assign w_ii = PW'(w_ai) * PW'(w_bi);
        assign w_ri = PW'(w_ar) * PW'(w_bi);
        assign w_ir = PW'(w_ai) * PW'(w_br);
        assign w_pr[k] = r_conj ? (w_rr + w_ii) : (w_rr - w_ii);
        assign w_pi[k] = r_conj ? (w_ri - w_ir) : (w_ri + w_ir);
    end

    always_comb begin
        w_sum_r = '0;
        w_sum_i = '0;
        for (int k = 0; k < LANES; k++) begin
            w_sum_r = w_sum_r + SW'(r_pr[k]);
            w_sum_i = w_sum_i + SW'(r_pi[k]);
        end
        w_sh_r = w_sum_r >>> FRAC;
        w_sh_i = w_sum_i >>> FRAC;
    end

    function automatic logic [WIDTH-1:0] f_sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX)      return SAT_MAX[WIDTH-1:0];
        else if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
        else                  return v[WIDTH-1:0];
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        o_busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_issue && (r_cnt == LAST_IDX)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_conj      <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_idx    <= '0;
            for (int k = 0; k < LANES; k++) begin
                r_pr[k] <= '0;
                r_pi[k] <= '0;
            end
            o_out_valid <= 1'b0;
            o_out_r     <= '0;
            o_out_i     <= '0;
            o_out_idx   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_last_hs;
            if ((r_state == S_IDLE) && i_start) begin
                r_conj <= i_conj;
                r_cnt  <= '0;
            end else if (w_issue && (r_cnt != LAST_IDX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Whole pipe moves together; a stalled output freezes stage 1 too.
            if (w_advance) begin
                r_s1_valid <= w_issue;
                if (w_issue) begin
                    r_s1_idx <= r_cnt;
                    r_pr     <= w_pr;
                    r_pi     <= w_pi;
                end
                if (r_s1_valid) begin
                    o_out_valid <= 1'b1;
                    o_out_r     <= f_sat(w_sh_r);
                    o_out_i     <= f_sat(w_sh_i);
                    o_out_idx   <= r_s1_idx;
                end else begin
                    o_out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ydot_engine.sv
// Directed bench for ydot_engine: latency, plain/conj math, truncation, saturation,
// backpressure and asynchronous reset, with hand-computed expectations.
module tb_ydot_engine;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;
    localparam int LANES = 4;
    localparam int NCOL  = 2;
    localparam int IW    = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic conj = 1'b0;
    logic out_ready = 1'b1;
    logic [LANES*WIDTH-1:0] row_r = '0, row_i = '0;
    logic [NCOL*LANES*WIDTH-1:0] col_r = '0, col_i = '0;
    logic out_valid, busy, done;
    logic [WIDTH-1:0] out_r, out_i;
    logic [IW-1:0] out_idx;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int base;

    ydot_engine #(.WIDTH(WIDTH), .FRAC(FRAC), .LANES(LANES), .NCOL(NCOL)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_conj(conj),
        .i_row_r(row_r), .i_row_i(row_i), .i_col_r(col_r), .i_col_i(col_i),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_r(out_r), .o_out_i(out_i), .o_out_idx(out_idx),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (out_valid && out_ready) hs_count <= hs_count + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_real(input logic [15:0] rv, input logic [15:0] c0, input logic [15:0] c1);
        row_i = '0;
        col_i = '0;
        for (int k = 0; k < LANES; k++) begin
            row_r[k*WIDTH +: WIDTH]         = rv;
            col_r[k*WIDTH +: WIDTH]         = c0;
            col_r[(LANES+k)*WIDTH +: WIDTH] = c1;
        end
    endtask

    task automatic run_job(input string tag, input logic cj,
                           input logic [15:0] er0, input logic [15:0] ei0,
                           input logic [15:0] er1, input logic [15:0] ei1);
        int n;
        conj = cj;
        start = 1'b1;
        step;
        start = 1'b0;
        conj = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            step;
            n++;
        end
        chk({tag, "_valid0"}, out_valid, 1);
        chk({tag, "_idx0"}, out_idx, 0);
        chk({tag, "_r0"}, out_r, er0);
        chk({tag, "_i0"}, out_i, ei0);
        step;
        chk({tag, "_valid1"}, out_valid, 1);
        chk({tag, "_idx1"}, out_idx, 1);
        chk({tag, "_r1"}, out_r, er1);
        chk({tag, "_i1"}, out_i, ei1);
        step;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_off"}, busy, 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_r", out_r, 0);
        chk("rst_i", out_i, 0);
        chk("rst_idx", out_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #5 rst_n = 1'b1;
        step; step; step;
        chk("idle_no_valid", out_valid, 0);
        chk("idle_no_busy", busy, 0);

        // Plain real, exact latency: 1.0*0.5*4 = 2.0, 1.0*-0.5*4 = -2.0
        set_real(16'h0100, 16'h0080, 16'hFF80);
        start = 1'b1;
        step;
        start = 1'b0;
        chk("t1_busy_e0", busy, 1);
        chk("t1_valid_e0", out_valid, 0);
        step;
        chk("t1_valid_e1", out_valid, 0);
        step;
        chk("t1_valid_e2", out_valid, 1);
        chk("t1_idx_e2", out_idx, 0);
        chk("t1_r_e2", out_r, 16'h0200);
        chk("t1_i_e2", out_i, 16'h0000);
        step;
        chk("t1_valid_e3", out_valid, 1);
        chk("t1_idx_e3", out_idx, 1);
        chk("t1_r_e3", out_r, 16'hFE00);
        chk("t1_i_e3", out_i, 16'h0000);
        chk("t1_done_e3", done, 0);
        step;
        chk("t1_done_e4", done, 1);
        chk("t1_busy_e4", busy, 0);
        chk("t1_valid_e4", out_valid, 0);
        step;
        chk("t1_done_pulse", done, 0);

        // Conj mode: col0 lane0 = (0, j), col1 lane0 = (1, 0); row lane0 = (0, j)
        row_r = '0; row_i = '0; col_r = '0; col_i = '0;
        row_i[0 +: WIDTH] = 16'h0100;
        col_i[0 +: WIDTH] = 16'h0100;
        col_r[LANES*WIDTH +: WIDTH] = 16'h0100;
        run_job("plain", 1'b0, 16'hFF00, 16'h0000, 16'h0000, 16'h0100);
        run_job("conj",  1'b1, 16'h0100, 16'h0000, 16'h0000, 16'hFF00);

        // Shift truncates toward -inf: -1 lsb^2 -> -1, +1 lsb^2 -> 0
        row_r = '0; row_i = '0; col_r = '0; col_i = '0;
        row_r[0 +: WIDTH] = 16'h0001;
        col_r[0 +: WIDTH] = 16'hFFFF;
        col_r[LANES*WIDTH +: WIDTH] = 16'h0001;
        run_job("trunc", 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);

        // Saturation both ways
        set_real(16'h7FFF, 16'h7FFF, 16'h8000);
        run_job("sat", 1'b0, 16'h7FFF, 16'h0000, 16'h8000, 16'h0000);

        // Backpressure with a start pulse while busy
        set_real(16'h0100, 16'h0080, 16'hFF80);
        base = hs_count;
        out_ready = 1'b0;
        start = 1'b1;
        step;
        start = 1'b0;
        step; step;
        chk("bp_valid", out_valid, 1);
        chk("bp_idx", out_idx, 0);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) start = 1'b1;
            step;
            start = 1'b0;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_idx", out_idx, 0);
            chk("bp_hold_r", out_r, 16'h0200);
            chk("bp_hold_i", out_i, 16'h0000);
        end
        out_ready = 1'b1;
        step;
        chk("bp_valid1", out_valid, 1);
        chk("bp_idx1", out_idx, 1);
        chk("bp_r1", out_r, 16'hFE00);
        step;
        chk("bp_done", done, 1);
        step; step;
        chk("bp_no_restart_busy", busy, 0);
        chk("bp_no_restart_valid", out_valid, 0);
        chk("bp_handshakes", hs_count - base, 2);

        // Asynchronous reset mid-job
        start = 1'b1;
        step;
        start = 1'b0;
        step; step;
        chk("mid_valid_pre", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_r", out_r, 0);
        chk("mid_idx", out_idx, 0);
        chk("mid_done", done, 0);
        #3 rst_n = 1'b1;
        step;
        chk("mid_after_valid", out_valid, 0);
        run_job("post", 1'b0, 16'h0200, 16'h0000, 16'hFE00, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ydot_engine.md
# ydot_engine

Parametrised complex dot-product engine for the SOML decoder datapath. For each of NCOL candidate columns it computes the full complex inner product of a received row Y with that column, in either plain or conjugate mode, over LANES lanes in signed Q(WIDTH-FRAC).FRAC. Results stream out through a valid/ready port, one column per cycle at full throughput. It sits between the column/channel tables and the metric/compare stages of the detector.

## Interface
- WIDTH, 16, sample width (signed two's complement)
- FRAC, 8, fractional bits
- LANES, 4, complex elements per dot product (>=1)
- NCOL, 2, columns per job (>=1)
- IW = max(1, $clog2(NCOL)), derived, index width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  job request; accepted only in IDLE
- conj  in  1  sampled with start; 1 = use conj(row)
- row_r, row_i  in  LANES*WIDTH  Y row; lane k at [k*WIDTH +: WIDTH]
- col_r, col_i  in  NCOL*LANES*WIDTH  columns; column c lane k at [(c*LANES+k)*WIDTH +: WIDTH]
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_r, out_i  out  WIDTH  dot product, saturated
- out_idx  out  IW  column index of result
- busy  out  1  job in progress
- done  out  1  one-cycle pulse, job complete

## Operation
- States: IDLE, RUN (issuing columns), DRAIN (all issued, results pending).
- IDLE -> RUN on start; conj latched, column counter cnt = 0, busy = 1.
- RUN: advance = !out_valid || out_ready. On advance, column cnt enters stage 1, cnt increments; after issuing NCOL-1 -> DRAIN.
- DRAIN -> IDLE on handshake (out_valid && out_ready) with out_idx == NCOL-1; done = 1 next cycle, busy = 0 same edge.
- Stall: when !advance, cnt, stage-1 registers and output register hold unchanged.
- row/col inputs must be stable while busy; they are not captured.
- start while busy ignored; start in the done cycle (state IDLE) accepted.
- Stage 1 (per lane, registered): plain pr = ar*br - ai*bi, pi = ar*bi + ai*br; conj pr = ar*br + ai*bi, pi = ar*bi - ai*br; full precision 2*WIDTH+1 bits.
- Stage 2 (registered to output): sum LANES lane products at full precision (2*WIDTH+1+$clog2(LANES) bits), arithmetic shift right FRAC (truncate toward -inf), saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Output register loads when advance and stage-1 valid; out_valid clears on handshake with no new result behind it.

## Timing
- Reset (async, any state incl. mid-job): state IDLE, cnt 0, stage-1 valid 0, out_valid 0, out_r/out_i/out_idx 0, busy 0, done 0, latched conj 0.
- start sampled at edge E0; column 0 products registered at E1; out_valid for column 0 at E2 (latency 2).
- No backpressure: column c valid at E(2+c); last result at E(NCOL+1); done high cycle after its handshake.
- Backpressure never drops or duplicates results; out_r/out_i/out_idx stable while out_valid && !out_ready.
- Results always in index order 0..NCOL-1.

## Test plan
- Reset: rst low at arbitrary times -> all outputs 0 immediately; after release no out_valid without start.
- Plain real: row_r lanes 0x0100, row_i 0, col0_r lanes 0x0080, col1_r lanes 0xFF80, col_i 0, out_ready 1 -> E2: out_r 0x0200 idx 0; E3: out_r 0xFE00 idx 1; out_i 0; done pulse cycle after E3.
- Conj mode: row lane0 = (0x0000, 0x0100), col0 lane0 = (0x0000, 0x0100), other lanes 0 -> conj=0: out_r 0xFF00, out_i 0; conj=1: out_r 0x0100, out_i 0.
- Saturation: all row/col real lanes 0x7FFF, imag 0 -> out_r 0x7FFF; col real 0x8000 -> out_r 0x8000.
- Backpressure: out_ready low 3 cycles when idx 0 valid -> outputs held; idx 1 valid cycle after accept; exactly NCOL handshakes; start pulsed while busy ignored.
- Reset mid-job: rst low during RUN with out_valid 1 -> out_valid/busy 0 at once; new start afterwards gives correct results from idx 0.
